water_heater_controller: RTL and testbench
==========================================

// Module: water_heater_controller
// PURPOSE
//  Consumes selected_temperature from the temperature incrementor and drives the drum water heater.
//  On a start request, latches the target. Heats until the measured water temperature reaches the target.
//  Holds the target with hysteresis for a settle window, then reports done to the wash sequencer.
//  A watchdog flags a fault when heating takes too long.
// PARAMETERS
//  HYSTERESIS     2    degC below target at which heating resumes (7-bit unsigned)
//  SETTLE_CYCLES  4    consecutive in-band cycles in HOLD required before DONE (>=1)
//  HEAT_TIMEOUT   600  max cycles spent in HEAT+HOLD before FAULT (>=2)
//  CNT_W          16   width of timeout/settle counters; must hold HEAT_TIMEOUT
//  OVERTEMP_LIMIT 95   degC trip point; used only with HEATER_OVERTEMP_EN
// PORTS
//  clk                   in   1  system clock
//  reset                 in   1  synchronous, active-high reset
//  start                 in   1  request heat cycle; sampled only in IDLE
//  abort                 in   1  cancel any cycle; highest priority after reset
//  clear                 in   1  acknowledge DONE/FAULT; return to IDLE
//  selected_temperature  in   7  target degC from incrementor; latched on accepted start
//  measured_temperature  in   7  water sensor reading, degC unsigned
//  heater_on             out  1  heater relay drive (registered)
//  heat_done             out  1  level, high while in DONE (registered)
//  heat_fault            out  1  level, high while in FAULT (registered)
//  state                 out  3  current FSM state code (debug/sequencer)
// BEHAVIOUR
//  - One clock, synchronous active-high reset.
//  - Reset: state=IDLE(0), heater_on=0, heat_done=0, heat_fault=0, target=0, counters=0.
//  - States: IDLE=0, LATCH=1, HEAT=2, HOLD=3, DONE=4, FAULT=5. Codes 6/7 are illegal and go to IDLE next cycle.
//  - All outputs are registered and consistent with state: heater_on asserts in the same cycle the state reads HEAT.
//  - Low threshold: lo = target - HYSTERESIS, saturating at 0.
//  - IDLE: start=1 -> LATCH; target <= selected_temperature in the same edge. timeout_cnt <= 0.
//  - LATCH (1 cycle):
//    - target==0 (cold wash) -> DONE directly.
//    - measured>=target -> HOLD.
//    - otherwise -> HEAT.
//  - HEAT: heater_on=1. timeout_cnt increments each cycle.
//    - measured>=target -> HOLD, settle_cnt <= 0.
//  - HOLD: heater_on=0.
//    - measured<lo -> HEAT.
//    - else settle_cnt increments; settle_cnt==SETTLE_CYCLES-1 while in band -> DONE.
//    - timeout_cnt keeps counting; it is not reset on a HOLD->HEAT re-entry.
//  - Timeout: in HEAT/HOLD, timeout_cnt==HEAT_TIMEOUT-1 -> FAULT. Timeout beats a settle completion in the same cycle.
//  - DONE: heat_done=1; clear=1 -> IDLE. FAULT: heat_fault=1, heater_on=0; sticky until clear or reset.
//  - abort=1 in any state except IDLE -> IDLE next cycle, heater_on=0. abort beats timeout, clear and start.
//  - start outside IDLE is ignored. selected_temperature changes after the latch are ignored until the next start.
//  - Reset mid-operation: next edge forces the reset values, heater off.
//  - Counters never wrap: timeout_cnt stops at HEAT_TIMEOUT-1 (FAULT is taken); settle_cnt resets whenever HOLD is left.
// CONFIGURATION
//  HEATER_OVERTEMP_EN defined:
//    - In HEAT/HOLD, measured_temperature >= OVERTEMP_LIMIT -> FAULT next cycle, heater_on=0.
//    - Priority is below abort and above timeout.
//  Undefined: no over-temperature check, and OVERTEMP_LIMIT is unused.
// TESTING (HEAT_TIMEOUT=20, SETTLE_CYCLES=4, HYSTERESIS=2 unless noted)
//  1. Reset, then start with sel=40, meas=20 -> LATCH, then HEAT with heater_on=1; meas=40 -> HOLD;
//     hold 4 cycles -> DONE, heat_done=1; clear -> IDLE.
//  2. sel=0, start -> LATCH -> DONE with heater_on never asserted.
//  3. In HOLD at target 60, drop meas to 57 -> HEAT, heater_on=1; raise meas to 60 -> HOLD, settle count restarts.
//  4. meas stuck at 20 with target 60 -> FAULT 20 cycles after entering HEAT; heat_fault stays 1 until clear.
//  5. abort in HEAT together with a timeout cycle -> IDLE, heater_on=0, heat_fault=0.
//     start during HEAT is ignored; reset during HOLD restores all reset values.
//  6. With HEATER_OVERTEMP_EN: target 90, meas jumps to 95 -> FAULT. Without the macro the same stimulus -> HOLD.

Source files
------------

// File: rtl/water_heater_controller.sv
`default_nettype none
// ============================================================================
// Module      : water_heater_controller
// Description : Drum water heater controller. It latches a target temperature
//               on start, heats to the target, then holds it with hysteresis
//               for a settle window before reporting done. A watchdog raises
//               a sticky fault if heating and holding together take too long.
//               Optional build macro HEATER_OVERTEMP_EN adds an
//               over-temperature trip (OVERTEMP_LIMIT) while heating or holding.
// Revision    : 1.0 - initial release
// ============================================================================
module water_heater_controller #(
    parameter int HYSTERESIS    = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int HEAT_TIMEOUT  = 600,
    parameter int CNT_W         = 16
`ifdef HEATER_OVERTEMP_EN
    ,
    parameter int OVERTEMP_LIMIT = 95
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       clear,
    input  logic [6:0] selected_temperature,
    input  logic [6:0] measured_temperature,
    output logic       heater_on,
    output logic       heat_done,
    output logic       heat_fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_HEAT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(HEAT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [6:0]       c_hyst         = 7'(HYSTERESIS);

    state_t           r_state;
    state_t           w_next_state;
    logic [6:0]       r_target;
    logic [CNT_W-1:0] r_timeout_cnt;
    logic [CNT_W-1:0] r_settle_cnt;
    logic             r_heater_on;
    logic             r_heat_done;
    logic             r_heat_fault;

    logic [6:0]       w_lo;
    logic             w_at_target;
    logic             w_below_lo;
    logic             w_timeout;
    logic             w_settled;
    logic             w_overtemp;
    logic             w_active;

    // Low hysteresis threshold, saturating at zero for small targets
    assign w_lo        = (r_target >= c_hyst) ? (r_target - c_hyst) : 7'd0;
    assign w_at_target = (measured_temperature >= r_target);
    assign w_below_lo  = (measured_temperature < w_lo);
    assign w_timeout   = (r_timeout_cnt == c_timeout_last);
    assign w_settled   = (r_settle_cnt == c_settle_last);
    assign w_active    = (r_state == S_HEAT) || (r_state == S_HOLD);

`ifdef HEATER_OVERTEMP_EN
    assign w_overtemp  = (measured_temperature >= 7'(OVERTEMP_LIMIT));
`else
    assign w_overtemp  = 1'b0;
`endif

    // Next-state decision; abort overrides everything, overtemp beats timeout,
    // timeout beats a settle completion or any other in-band move
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LATCH;
                end
            end
            S_LATCH: begin
                if (r_target == 7'd0) begin
                    w_next_state = S_DONE;
                end else if (w_at_target) begin
                    w_next_state = S_HOLD;
                end else begin
                    w_next_state = S_HEAT;
                end
            end
            S_HEAT: begin
                if (w_overtemp || w_timeout) begin
                    w_next_state = S_FAULT;
                end else if (w_at_target) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_overtemp || w_timeout) begin
                    w_next_state = S_FAULT;
                end else if (w_below_lo) begin
                    w_next_state = S_HEAT;
                end else if (w_settled) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE, S_FAULT: begin
                if (clear) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (abort) begin
            w_next_state = S_IDLE;
        end
    end

    // State register with outputs decoded from the next state so they line up
    // with the state code in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_heater_on  <= 1'b0;
            r_heat_done  <= 1'b0;
            r_heat_fault <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_heater_on  <= (w_next_state == S_HEAT);
            r_heat_done  <= (w_next_state == S_DONE);
            r_heat_fault <= (w_next_state == S_FAULT);
        end
    end

    // Target is captured only on an accepted start; later selector changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            r_target <= 7'd0;
        end else if ((r_state == S_IDLE) && start && !abort) begin
            r_target <= selected_temperature;
        end
    end

    // Watchdog spans HEAT and HOLD together and saturates at its trip value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_timeout_cnt <= '0;
        end else if (w_active && !w_timeout) begin
            r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
        end
    end

    // Settle counter runs only while staying in HOLD and restarts on any exit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle_cnt <= '0;
        end else if ((r_state == S_HOLD) && (w_next_state == S_HOLD)) begin
            r_settle_cnt <= r_settle_cnt + CNT_W'(1);
        end else begin
            r_settle_cnt <= '0;
        end
    end

    assign heater_on  = r_heater_on;
    assign heat_done  = r_heat_done;
    assign heat_fault = r_heat_fault;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_water_heater_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_water_heater_controller
// Description : Directed-vector scoreboard bench for water_heater_controller.
//               Each stimulus cycle pushes the hand-computed expected state;
//               a monitor pops and compares one entry per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_water_heater_controller;

    localparam logic [2:0] S_I  = 3'd0;
    localparam logic [2:0] S_L  = 3'd1;
    localparam logic [2:0] S_H  = 3'd2;
    localparam logic [2:0] S_HO = 3'd3;
    localparam logic [2:0] S_D  = 3'd4;
    localparam logic [2:0] S_F  = 3'd5;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] sel   = 7'd0;
    logic [6:0] meas  = 7'd0;
    logic       heater_on;
    logic       heat_done;
    logic       heat_fault;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic       h;
        logic       d;
        logic       f;
    } exp_t;

    exp_t exp_q[$];
    int   tag_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec    = 0;

    water_heater_controller #(
        .HYSTERESIS    (2),
        .SETTLE_CYCLES (4),
        .HEAT_TIMEOUT  (20),
        .CNT_W         (16)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .abort                (abort),
        .clear                (clear),
        .selected_temperature (sel),
        .measured_temperature (meas),
        .heater_on            (heater_on),
        .heat_done            (heat_done),
        .heat_fault           (heat_fault),
        .state                (state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the state expected after the next edge
    task automatic cyc(input logic r, input logic s, input logic a, input logic c,
                       input logic [6:0] sv, input logic [6:0] mv, input logic [2:0] es);
        exp_t e;
        @(negedge clk);
        reset = r;
        start = s;
        abort = a;
        clear = c;
        sel   = sv;
        meas  = mv;
        e.st  = es;
        e.h   = (es == S_H);
        e.d   = (es == S_D);
        e.f   = (es == S_F);
        vec++;
        exp_q.push_back(e);
        tag_q.push_back(vec);
    endtask

    // Monitor: one observation per clock, checked against the queue head
    initial begin
        exp_t e;
        int   t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if ({state, heater_on, heat_done, heat_fault} !== e) begin
                    errors++;
                    $display("FAIL vec%0d: got state=%0d heater=%b done=%b fault=%b, expected state=%0d heater=%b done=%b fault=%b",
                             t, state, heater_on, heat_done, heat_fault, e.st, e.h, e.d, e.f);
                end
            end
        end
    end

    // Global time guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 7'd0, 7'd0, S_I);
        cyc(1, 1, 0, 0, 7'd40, 7'd0, S_I);
        cyc(0, 0, 0, 0, 7'd0, 7'd0, S_I);

        // 1: heat to 40, settle, done, clear; selector changes after latch ignored
        cyc(0, 1, 0, 0, 7'd40, 7'd20, S_L);
        cyc(0, 0, 0, 0, 7'd99, 7'd20, S_H);
        cyc(0, 0, 0, 0, 7'd99, 7'd20, S_H);
        cyc(0, 0, 0, 0, 7'd99, 7'd40, S_HO);
        cyc(0, 0, 0, 0, 7'd99, 7'd40, S_HO);
        cyc(0, 0, 0, 0, 7'd99, 7'd40, S_HO);
        cyc(0, 0, 0, 0, 7'd99, 7'd40, S_HO);
        cyc(0, 0, 0, 0, 7'd99, 7'd40, S_D);
        cyc(0, 0, 0, 0, 7'd99, 7'd40, S_D);
        cyc(0, 0, 0, 1, 7'd99, 7'd40, S_I);

        // 2: cold wash
        cyc(0, 1, 0, 0, 7'd0, 7'd20, S_L);
        cyc(0, 0, 0, 0, 7'd0, 7'd20, S_D);
        cyc(0, 0, 0, 1, 7'd0, 7'd20, S_I);

        // 3: hysteresis re-entry, settle restart, lo boundary (58 stays in band)
        cyc(0, 1, 0, 0, 7'd60, 7'd60, S_L);
        cyc(0, 0, 0, 0, 7'd60, 7'd60, S_HO);
        cyc(0, 0, 0, 0, 7'd60, 7'd60, S_HO);
        cyc(0, 0, 0, 0, 7'd60, 7'd57, S_H);
        cyc(0, 0, 0, 0, 7'd60, 7'd60, S_HO);
        cyc(0, 0, 0, 0, 7'd60, 7'd58, S_HO);
        cyc(0, 0, 0, 0, 7'd60, 7'd60, S_HO);
        cyc(0, 0, 0, 0, 7'd60, 7'd60, S_HO);
        cyc(0, 0, 0, 0, 7'd60, 7'd60, S_D);
        cyc(0, 0, 0, 1, 7'd60, 7'd60, S_I);

        // 4: stuck sensor -> fault 20 cycles after HEAT entry; start ignored; fault sticky
        cyc(0, 1, 0, 0, 7'd60, 7'd20, S_L);
        cyc(0, 0, 0, 0, 7'd60, 7'd20, S_H);
        for (int i = 0; i < 19; i++) begin
            cyc(0, (i % 3 == 0) ? 1'b1 : 1'b0, 0, 0, 7'd60, 7'd20, S_H);
        end
        cyc(0, 0, 0, 0, 7'd60, 7'd20, S_F);
        cyc(0, 1, 0, 0, 7'd60, 7'd20, S_F);
        cyc(0, 0, 0, 0, 7'd60, 7'd60, S_F);
        cyc(0, 0, 0, 1, 7'd60, 7'd20, S_I);

        // 5: abort beats timeout in the same cycle
        cyc(0, 1, 0, 0, 7'd60, 7'd20, S_L);
        cyc(0, 0, 0, 0, 7'd60, 7'd20, S_H);
        for (int i = 0; i < 19; i++) begin
            cyc(0, 0, 0, 0, 7'd60, 7'd20, S_H);
        end
        cyc(0, 0, 1, 1, 7'd60, 7'd20, S_I);
        cyc(0, 0, 0, 0, 7'd60, 7'd20, S_I);

        // 5b: reset during HOLD, then a fresh cycle shows cleared counters
        cyc(0, 1, 0, 0, 7'd50, 7'd50, S_L);
        cyc(0, 0, 0, 0, 7'd50, 7'd50, S_HO);
        cyc(0, 0, 0, 0, 7'd50, 7'd50, S_HO);
        cyc(1, 0, 0, 0, 7'd50, 7'd50, S_I);
        cyc(0, 0, 0, 0, 7'd50, 7'd50, S_I);
        cyc(0, 1, 0, 0, 7'd50, 7'd50, S_L);
        cyc(0, 0, 0, 0, 7'd50, 7'd50, S_HO);
        cyc(0, 0, 0, 0, 7'd50, 7'd50, S_HO);
        cyc(0, 0, 0, 0, 7'd50, 7'd50, S_HO);
        cyc(0, 0, 0, 0, 7'd50, 7'd50, S_HO);
        cyc(0, 0, 0, 0, 7'd50, 7'd50, S_D);
        cyc(0, 0, 1, 0, 7'd50, 7'd50, S_I);

        // Saturating low threshold: target 1, meas 0 never drops below lo=0
        cyc(0, 1, 0, 0, 7'd1, 7'd0, S_L);
        cyc(0, 0, 0, 0, 7'd1, 7'd0, S_H);
        cyc(0, 0, 0, 0, 7'd1, 7'd1, S_HO);
        cyc(0, 0, 0, 0, 7'd1, 7'd0, S_HO);
        cyc(0, 0, 0, 0, 7'd1, 7'd0, S_HO);
        cyc(0, 0, 0, 0, 7'd1, 7'd0, S_HO);
        cyc(0, 0, 0, 0, 7'd1, 7'd0, S_D);
        cyc(0, 0, 0, 1, 7'd1, 7'd0, S_I);

        // 6: over-temperature (fault only when the trip is built in)
        cyc(0, 1, 0, 0, 7'd90, 7'd80, S_L);
        cyc(0, 0, 0, 0, 7'd90, 7'd80, S_H);
`ifdef HEATER_OVERTEMP_EN
        cyc(0, 0, 0, 0, 7'd90, 7'd95, S_F);
`else
        cyc(0, 0, 0, 0, 7'd90, 7'd95, S_HO);
`endif
        cyc(0, 0, 1, 0, 7'd90, 7'd95, S_I);

        // Let the monitor drain the last expectation
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
